// File: rtl/board_column_writer.sv
`default_nettype none
// ============================================================================
// Module      : board_column_writer
// Description : Serialises a queen placement (one row index per column) into
//               one-hot column words over a valid/ready write port.
//               Optional macro CONFLICT_CHECK_EN adds a row-conflict flag.
// Revision    : 1.0 - initial release
// ============================================================================
module board_column_writer #(
    parameter int N     = 8,
    parameter int ROW_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N*ROW_W-1:0]   rows_in,
    output logic                 busy,
    output logic                 wr_valid,
    input  logic                 wr_ready,
    output logic [ROW_W-1:0]     col_addr,
    output logic [N-1:0]         column_content,
    output logic                 done,
    output logic                 conflict
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [ROW_W-1:0] c_LAST_COL = ROW_W'(N - 1);

    state_t             r_state;
    logic [ROW_W-1:0]   r_rows [N];
    logic [ROW_W-1:0]   r_col_addr;
    logic [N-1:0]       r_column_content;
    logic               r_busy;
    logic               r_wr_valid;
    logic               r_done;

    logic               w_accept;
    logic [ROW_W-1:0]   w_next_addr;
    logic [ROW_W-1:0]   w_next_row;

    // Out-of-range indices (non-power-of-two N) encode as an empty column.
    function automatic logic [N-1:0] f_onehot(input logic [ROW_W-1:0] row);
        logic [N-1:0] res;
        res = '0;
        if (int'(row) < N) begin
            res[row] = 1'b1;
        end
        return res;
    endfunction

    assign w_accept    = r_wr_valid & wr_ready;
    assign w_next_addr = r_col_addr + ROW_W'(1);
    assign w_next_row  = r_rows[w_next_addr];

`ifdef CONFLICT_CHECK_EN
    logic [N-1:0]       r_used;
    logic               r_conflict;
    logic [ROW_W-1:0]   w_cur_row;

    assign w_cur_row = r_rows[r_col_addr];
    assign conflict  = r_conflict;
`else
    assign conflict  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_col_addr       <= '0;
            r_column_content <= '0;
            r_busy           <= 1'b0;
            r_wr_valid       <= 1'b0;
            r_done           <= 1'b0;
            for (int c = 0; c < N; c++) begin
                r_rows[c] <= '0;
            end
`ifdef CONFLICT_CHECK_EN
            r_used           <= '0;
            r_conflict       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        for (int c = 0; c < N; c++) begin
                            r_rows[c] <= rows_in[c*ROW_W +: ROW_W];
                        end
                        r_col_addr       <= '0;
                        r_column_content <= f_onehot(rows_in[0 +: ROW_W]);
                        r_wr_valid       <= 1'b1;
                        r_busy           <= 1'b1;
                        r_state          <= S_WRITE;
`ifdef CONFLICT_CHECK_EN
                        r_used           <= '0;
                        r_conflict       <= 1'b0;
`endif
                    end
                end

                S_WRITE: begin
                    if (w_accept) begin
`ifdef CONFLICT_CHECK_EN
                        if ((int'(w_cur_row) >= N) || r_used[w_cur_row]) begin
                            r_conflict <= 1'b1;
                        end
                        if (int'(w_cur_row) < N) begin
                            r_used[w_cur_row] <= 1'b1;
                        end
`endif
                        if (r_col_addr == c_LAST_COL) begin
                            r_wr_valid       <= 1'b0;
                            r_column_content <= '0;
                            r_done           <= 1'b1;
                            r_state          <= S_DONE;
                        end else begin
                            r_col_addr       <= w_next_addr;
                            r_column_content <= f_onehot(w_next_row);
                        end
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign wr_valid       = r_wr_valid;
    assign col_addr       = r_col_addr;
    assign column_content = r_column_content;
    assign done           = r_done;

endmodule
`default_nettype wire
